spi_bitrev_slave: RTL and testbench

Parametrised SPI slave peripheral for the NPC perip test set: a full-duplex successor to the single-shot 8-bit bit-reversal target. Within one SS assertion it accepts back-to-back frames of DATA_W bits and returns, in each frame, the (optionally bit-reversed) word captured in the previous frame. It runs on the system clock, oversamples SCK/SS/MOSI, supports all four SPI modes, and reports captured words and aborted frames to a local observer.

---
 rtl/spi_bitrev_slave.sv | 183 ++++++++++++++++++
 tb/tb_spi_bitrev_slave.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_bitrev_slave.sv
// Full-duplex SPI slave: captures DATA_W-bit frames and returns the previous frame's word, bit-reversed when REVERSE is set.
// Latency: every pin event (sck edge, ss edge) acts 3 clock cycles later (2 sync + 1 edge detect).
// Backpressure: none. The master paces all traffic and must respect the minimum sck phase and ss setup/hold times.
//
// Ports:
//   clock, reset_n      system clock and asynchronous active-low reset
//   sck, ss, mosi       asynchronous SPI pins, oversampled on clock
//   miso, miso_oe       slave data out (1 when deselected) and its output enable
//   rx_data, rx_valid   last complete received word and its one-cycle update strobe
//   frame_abort         one-cycle pulse when ss rises in the middle of a frame
module spi_bitrev_slave #(
   parameter int                DATA_W  = 8,
   parameter bit                CPOL    = 1'b0,
   parameter bit                CPHA    = 1'b0,
   parameter bit                REVERSE = 1'b1,
   parameter logic [DATA_W-1:0] FILL    = '1
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              sck,
   input  logic              ss,
   input  logic              mosi,
   output logic              miso,
   output logic              miso_oe,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              frame_abort
);

   localparam int CNT_W = $clog2(DATA_W);

   typedef enum logic {IDLE, ACTIVE} state_t;

   state_t state_q, state_d;

   // [0],[1] form the synchroniser; [2] is the previous synchronised value for edge detection
   logic [2:0] sck_sync;
   logic [2:0] ss_sync;
   logic [1:0] mosi_sync;

   logic [CNT_W-1:0]  bit_cnt;
   logic [DATA_W-1:0] rx_sh;
   logic [DATA_W-1:0] tx_sh;
   logic [DATA_W-1:0] pending;
   logic              pend_vld;
   logic              reload;

   logic              lead_edge, trail_edge;
   logic              sample_edge, shift_edge;
   logic              ss_fall, ss_rise;
   logic              enter, leave;
   logic              do_sample, do_shift;
   logic              last_bit;
   logic [DATA_W-1:0] rx_word;
   logic [DATA_W-1:0] rev_word;
   logic [DATA_W-1:0] result;
   logic [DATA_W-1:0] load_word;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sck_sync  <= {3{CPOL}};
         ss_sync   <= 3'b111;
         mosi_sync <= 2'b11;
      end else begin
         sck_sync  <= {sck_sync[1:0], sck};
         ss_sync   <= {ss_sync[1:0], ss};
         mosi_sync <= {mosi_sync[0], mosi};
      end
   end

   always_comb begin
      lead_edge   = (sck_sync[2] == CPOL) && (sck_sync[1] != CPOL);
      trail_edge  = (sck_sync[2] != CPOL) && (sck_sync[1] == CPOL);
      sample_edge = CPHA ? trail_edge : lead_edge;
      shift_edge  = CPHA ? lead_edge : trail_edge;
      ss_fall     = ss_sync[2] & ~ss_sync[1];
      ss_rise     = ~ss_sync[2] & ss_sync[1];
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      enter   = 1'b0;
      leave   = 1'b0;
      case (state_q)
         IDLE: begin
            if (ss_fall) begin
               state_d = ACTIVE;
               enter   = 1'b1;
            end
         end
         ACTIVE: begin
            if (ss_rise) begin
               state_d = IDLE;
               leave   = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      do_sample = (state_q == ACTIVE) && !ss_rise && sample_edge;
      do_shift  = (state_q == ACTIVE) && !ss_rise && shift_edge;
      last_bit  = (bit_cnt == CNT_W'(DATA_W - 1));
      rx_word   = {rx_sh[DATA_W-2:0], mosi_sync[1]};
      rev_word  = '0;
      for (int i = 0; i < DATA_W; i++) begin
         rev_word[i] = rx_word[DATA_W-1-i];
      end
      result    = REVERSE ? rev_word : rx_word;
      load_word = pend_vld ? pending : FILL;
   end

   assign miso_oe = (state_q == ACTIVE);

   // The pending word stays valid until a frame that carried it completes (which
   // overwrites it with the new result). A word loaded at the end of a session, or
   // carried by an aborted frame, is therefore offered again in the next session.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         miso        <= 1'b1;
         rx_data     <= '0;
         rx_valid    <= 1'b0;
         frame_abort <= 1'b0;
         bit_cnt     <= '0;
         rx_sh       <= '0;
         tx_sh       <= '0;
         pending     <= '0;
         pend_vld    <= 1'b0;
         reload      <= 1'b0;
      end else begin
         rx_valid    <= 1'b0;
         frame_abort <= 1'b0;
         if (enter) begin
            bit_cnt <= '0;
            reload  <= 1'b0;
            tx_sh   <= load_word;
            // CPHA=0 presents the MSB before the first edge; CPHA=1 waits for the first shift edge
            miso    <= CPHA ? 1'b1 : load_word[DATA_W-1];
         end else if (leave) begin
            frame_abort <= (bit_cnt != '0);
            bit_cnt     <= '0;
            reload      <= 1'b0;
            miso        <= 1'b1;
         end else begin
            if (do_sample) begin
               if (last_bit) begin
                  bit_cnt  <= '0;
                  rx_data  <= rx_word;
                  rx_valid <= 1'b1;
                  pending  <= result;
                  pend_vld <= 1'b1;
                  reload   <= 1'b1;
               end else begin
                  bit_cnt <= bit_cnt + CNT_W'(1);
                  rx_sh   <= rx_word;
               end
            end
            if (do_shift) begin
               if (reload) begin
                  // First shift edge of a new frame in the same session: present the new MSB
                  reload <= 1'b0;
                  miso   <= load_word[DATA_W-1];
                  tx_sh  <= CPHA ? (load_word << 1) : load_word;
               end else begin
                  // CPHA=0: tx_sh[MSB] is already on miso, so the next bit is one below it
                  miso  <= CPHA ? tx_sh[DATA_W-1] : tx_sh[DATA_W-2];
                  tx_sh <= tx_sh << 1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_spi_bitrev_slave.sv
module tb_spi_bitrev_slave;

   // Instance 0: mode 0, 8 bit, reversed. 1: mode 3, 8 bit, echo.
   // Instance 2: mode 1, 16 bit, reversed. 3: mode 2, 8 bit, reversed.
   localparam logic [3:0] CPOL_C = 4'b1010;
   localparam logic [3:0] CPHA_C = 4'b0110;

   typedef struct packed {
      int          idx;
      logic [31:0] dat;
   } sb_t;

   logic        clock;
   logic        reset_n;
   logic [3:0]  sck_v;
   logic [3:0]  ss_v;
   logic [3:0]  mosi_v;

   logic        miso0, miso1, miso2, miso3;
   logic        oe0, oe1, oe2, oe3;
   logic        rxv0, rxv1, rxv2, rxv3;
   logic        ab0, ab1, ab2, ab3;
   logic [7:0]  rx0, rx1, rx3;
   logic [15:0] rx2;

   logic [3:0]  miso_v, rxv_v, ab_v, prev_rxv;
   assign miso_v = {miso3, miso2, miso1, miso0};
   assign rxv_v  = {rxv3, rxv2, rxv1, rxv0};
   assign ab_v   = {ab3, ab2, ab1, ab0};

   int   checks = 0;
   int   errors = 0;
   int   rxv_cnt [4];
   int   ab_cnt [4];
   sb_t  sb_q [$];

   spi_bitrev_slave #(.DATA_W(8), .CPOL(1'b0), .CPHA(1'b0), .REVERSE(1'b1)) u0 (
      .clock(clock), .reset_n(reset_n), .sck(sck_v[0]), .ss(ss_v[0]), .mosi(mosi_v[0]),
      .miso(miso0), .miso_oe(oe0), .rx_data(rx0), .rx_valid(rxv0), .frame_abort(ab0));
   spi_bitrev_slave #(.DATA_W(8), .CPOL(1'b1), .CPHA(1'b1), .REVERSE(1'b0)) u1 (
      .clock(clock), .reset_n(reset_n), .sck(sck_v[1]), .ss(ss_v[1]), .mosi(mosi_v[1]),
      .miso(miso1), .miso_oe(oe1), .rx_data(rx1), .rx_valid(rxv1), .frame_abort(ab1));
   spi_bitrev_slave #(.DATA_W(16), .CPOL(1'b0), .CPHA(1'b1), .REVERSE(1'b1)) u2 (
      .clock(clock), .reset_n(reset_n), .sck(sck_v[2]), .ss(ss_v[2]), .mosi(mosi_v[2]),
      .miso(miso2), .miso_oe(oe2), .rx_data(rx2), .rx_valid(rxv2), .frame_abort(ab2));
   spi_bitrev_slave #(.DATA_W(8), .CPOL(1'b1), .CPHA(1'b0), .REVERSE(1'b1)) u3 (
      .clock(clock), .reset_n(reset_n), .sck(sck_v[3]), .ss(ss_v[3]), .mosi(mosi_v[3]),
      .miso(miso3), .miso_oe(oe3), .rx_data(rx3), .rx_valid(rxv3), .frame_abort(ab3));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] rev_w(input logic [31:0] v, input int w);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < w; i++) r[i] = v[w-1-i];
      return r;
   endfunction

   function automatic logic [31:0] rx_of(input int i);
      case (i)
         0: return {24'd0, rx0};
         1: return {24'd0, rx1};
         2: return {16'd0, rx2};
         default: return {24'd0, rx3};
      endcase
   endfunction

   // Scoreboard consumer: each rx_valid pops the word queued when its frame was driven
   always @(negedge clock) begin
      for (int i = 0; i < 4; i++) begin
         if (rxv_v[i] === 1'b1) begin
            sb_t e;
            rxv_cnt[i]++;
            chk("rx_valid_width", {31'd0, prev_rxv[i]}, 32'd0);
            chk("sb_nonempty", {31'd0, sb_q.size() > 0}, 32'd1);
            if (sb_q.size() > 0) begin
               e = sb_q.pop_front();
               chk("sb_idx", i, e.idx);
               chk("rx_data", rx_of(i), e.dat);
            end
         end
         if (ab_v[i] === 1'b1) ab_cnt[i]++;
      end
      prev_rxv = rxv_v;
   end

   task automatic sel(input int idx);
      ss_v[idx] = 1'b0;
      repeat (6) @(negedge clock);
   endtask

   task automatic desel(input int idx);
      repeat (6) @(negedge clock);
      ss_v[idx] = 1'b1;
      repeat (8) @(negedge clock);
   endtask

   // Master side of one frame (or nbits of it); returns the bits seen on miso
   task automatic xfer(input int idx, input logic [31:0] word, input int nbits,
                       input int half, output logic [31:0] got);
      int w;
      w   = (idx == 2) ? 16 : 8;
      got = '0;
      if (nbits == w) sb_q.push_back('{idx: idx, dat: word});
      for (int b = 0; b < nbits; b++) begin
         logic bitv;
         bitv = word[w-1-b];
         if (!CPHA_C[idx]) begin
            mosi_v[idx] = bitv;
            repeat (half) @(negedge clock);
            got = {got[30:0], miso_v[idx]};
            sck_v[idx] = ~CPOL_C[idx];
            repeat (half) @(negedge clock);
            sck_v[idx] = CPOL_C[idx];
         end else begin
            sck_v[idx] = ~CPOL_C[idx];
            mosi_v[idx] = bitv;
            repeat (half) @(negedge clock);
            got = {got[30:0], miso_v[idx]};
            sck_v[idx] = CPOL_C[idx];
            repeat (half) @(negedge clock);
         end
      end
   endtask

   task automatic pulse_reset();
      @(negedge clock);
      reset_n = 1'b0;
      repeat (3) @(negedge clock);
      reset_n = 1'b1;
      repeat (3) @(negedge clock);
   endtask

   initial begin
      logic [31:0] got, exp_w;
      int          rv0, ab0n;
      for (int i = 0; i < 4; i++) begin
         rxv_cnt[i] = 0;
         ab_cnt[i]  = 0;
      end
      prev_rxv = '0;
      sck_v    = CPOL_C;
      ss_v     = 4'hF;
      mosi_v   = 4'h0;
      reset_n  = 1'b1;
      #2 reset_n = 1'b0;
      repeat (3) @(negedge clock);
      chk("reset_miso", {31'd0, miso0}, 32'd1);
      chk("reset_miso_oe", {31'd0, oe0}, 32'd0);
      chk("reset_rx_data", {24'd0, rx0}, 32'd0);
      chk("reset_rx_valid", {31'd0, rxv0}, 32'd0);
      chk("reset_frame_abort", {31'd0, ab0}, 32'd0);
      reset_n = 1'b1;
      repeat (3) @(negedge clock);

      // Mode 0: miso_oe lags ss by 3 cycles, then frames 0xC1, 0x00
      ss_v[0] = 1'b0;
      repeat (2) @(negedge clock);
      chk("oe_lag_2", {31'd0, oe0}, 32'd0);
      @(negedge clock);
      chk("oe_lag_3", {31'd0, oe0}, 32'd1);
      repeat (3) @(negedge clock);
      xfer(0, 32'hC1, 8, 6, got);
      chk("m0_frame1_miso", got, 32'hFF);
      xfer(0, 32'h00, 8, 6, got);
      chk("m0_frame2_miso", got, 32'h83);
      desel(0);
      chk("m0_oe_after_ss", {31'd0, oe0}, 32'd0);
      chk("m0_miso_idle", {31'd0, miso0}, 32'd1);
      chk("m0_rx_valid_cnt", rxv_cnt[0], 2);
      chk("m0_abort_cnt", ab_cnt[0], 0);

      // Mode 3, echo: three back-to-back frames
      sel(1);
      xfer(1, 32'h12, 8, 6, got);
      chk("m3_f1", got, 32'hFF);
      xfer(1, 32'h34, 8, 6, got);
      chk("m3_f2", got, 32'h12);
      xfer(1, 32'h56, 8, 6, got);
      chk("m3_f3", got, 32'h34);
      desel(1);
      chk("m3_rx_valid_cnt", rxv_cnt[1], 3);

      // Mode 1, 16 bit: pending word survives ss deassertion
      sel(2);
      xfer(2, 32'h1234, 16, 6, got);
      chk("m1_s1", got, 32'hFFFF);
      desel(2);
      sel(2);
      xfer(2, 32'h0000, 16, 6, got);
      chk("m1_s2", got, 32'h2C48);
      desel(2);

      // Abort after a complete 0xC1 frame
      pulse_reset();
      sel(0);
      xfer(0, 32'hC1, 8, 6, got);
      chk("ab_first", got, 32'hFF);
      desel(0);
      rv0  = rxv_cnt[0];
      ab0n = ab_cnt[0];
      sel(0);
      xfer(0, 32'h00, 3, 6, got);
      chk("ab_partial_bits", got, 32'h4);
      desel(0);
      chk("ab_pulse_cnt", ab_cnt[0] - ab0n, 1);
      chk("ab_no_rx_valid", rxv_cnt[0] - rv0, 0);
      chk("ab_rx_data_kept", {24'd0, rx0}, 32'hC1);
      sel(0);
      xfer(0, 32'h00, 8, 6, got);
      chk("ab_next_session", got, 32'h83);
      desel(0);

      // Reset in the middle of a frame
      rv0  = rxv_cnt[0];
      ab0n = ab_cnt[0];
      sel(0);
      xfer(0, 32'hA5, 5, 6, got);
      reset_n = 1'b0;
      #1;
      chk("rst_mid_miso", {31'd0, miso0}, 32'd1);
      chk("rst_mid_oe", {31'd0, oe0}, 32'd0);
      chk("rst_mid_rx_data", {24'd0, rx0}, 32'd0);
      ss_v[0] = 1'b1;
      repeat (4) @(negedge clock);
      reset_n = 1'b1;
      repeat (4) @(negedge clock);
      chk("rst_no_rx_valid", rxv_cnt[0] - rv0, 0);
      chk("rst_no_abort", ab_cnt[0] - ab0n, 0);
      sel(0);
      xfer(0, 32'h5A, 8, 6, got);
      chk("rst_first_frame", got, 32'hFF);
      desel(0);

      // Mode 2 at minimum timing: 50 random frames in one session
      sel(3);
      exp_w = 32'hFF;
      for (int k = 0; k < 50; k++) begin
         logic [31:0] w8;
         w8 = 32'($urandom_range(0, 255));
         xfer(3, w8, 8, 4, got);
         chk("m2_miso", got, exp_w);
         exp_w = rev_w(w8, 8);
      end
      desel(3);
      chk("m2_rx_valid_cnt", rxv_cnt[3], 50);
      chk("sb_drained", sb_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
